// File: rtl/dcache_direct_wt_if.sv
// CPU-side and RAM-side signal bundle for the direct-mapped write-through data cache.
// The slave modport is the cache's view; the master modport is the pipeline plus RAM around it.
interface dcache_direct_wt_if #(
  parameter int ADDRESS_LENGTH = 32
);
  logic [ADDRESS_LENGTH-1:0] cpu_a;
  logic [ADDRESS_LENGTH-1:0] cpu_wd;
  logic                      cpu_re;
  logic                      cpu_sw;
  logic                      cpu_sh;
  logic                      cpu_sb;
  logic [ADDRESS_LENGTH-1:0] cpu_rd;
  logic                      stall;
  logic [ADDRESS_LENGTH-1:0] mem_a;
  logic [ADDRESS_LENGTH-1:0] mem_wd;
  logic                      mem_sw;
  logic                      mem_sh;
  logic                      mem_sb;
  logic [ADDRESS_LENGTH-1:0] mem_rd;
  logic [31:0]               hit_count;
  logic [31:0]               miss_count;

  modport master (
    output cpu_a, cpu_wd, cpu_re, cpu_sw, cpu_sh, cpu_sb, mem_rd,
    input  cpu_rd, stall, mem_a, mem_wd, mem_sw, mem_sh, mem_sb, hit_count, miss_count
  );

  modport slave (
    input  cpu_a, cpu_wd, cpu_re, cpu_sw, cpu_sh, cpu_sb, mem_rd,
    output cpu_rd, stall, mem_a, mem_wd, mem_sw, mem_sh, mem_sb, hit_count, miss_count
  );
endinterface

// File: rtl/dcache_direct_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Load misses stall for the miss cycle plus one FILL cycle; stores pass straight to RAM.
module dcache_direct_wt #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int SETS           = 64
) (
  input  logic               clk,
  input  logic               rst,
  dcache_direct_wt_if.slave  bus
);
  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = ADDRESS_LENGTH - INDEX_BITS - 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [SETS-1:0]           valid_q, valid_d;
  logic [31:0]               hit_count_q, hit_count_d;
  logic [31:0]               miss_count_q, miss_count_d;
  logic [TAG_BITS-1:0]       tag_q  [SETS];
  logic [ADDRESS_LENGTH-1:0] line_q [SETS];

  logic [INDEX_BITS-1:0]     idx;
  logic [TAG_BITS-1:0]       tag;
  logic [1:0]                off;
  logic                      store;
  logic                      hit;
  logic [2:0]                acc_size;
  logic [2:0]                off_end;
  logic                      contained;
  logic [3:0]                be;
  logic [ADDRESS_LENGTH-1:0] wd_shift;
  logic [ADDRESS_LENGTH-1:0] line_cur;
  logic [ADDRESS_LENGTH-1:0] line_merge;
  logic [ADDRESS_LENGTH-1:0] line_wdata;
  logic                      line_we;
  logic                      tag_we;

  logic [ADDRESS_LENGTH-1:0] cpu_rd_c;
  logic [ADDRESS_LENGTH-1:0] mem_a_c;
  logic                      stall_c;
  logic                      mem_sw_c, mem_sh_c, mem_sb_c;

  assign off      = bus.cpu_a[1:0];
  assign idx      = bus.cpu_a[INDEX_BITS+1:2];
  assign tag      = bus.cpu_a[ADDRESS_LENGTH-1:INDEX_BITS+2];
  assign store    = bus.cpu_sw | bus.cpu_sh | bus.cpu_sb;
  assign line_cur = line_q[idx];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  // Effective access width follows the RAM's strobe priority sb > sh > sw.
  assign acc_size  = bus.cpu_sb ? 3'd1 : (bus.cpu_sh ? 3'd2 : 3'd4);
  assign off_end   = {1'b0, off} + acc_size;
  assign contained = (off_end <= 3'd4);
  assign wd_shift  = bus.cpu_wd << {off, 3'b000};

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign be[gi] = (3'(gi) >= {1'b0, off}) && (3'(gi) < off_end);
    assign line_merge[8*gi +: 8] = be[gi] ? wd_shift[8*gi +: 8] : line_cur[8*gi +: 8];
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    line_wdata   = line_merge;
    stall_c      = 1'b0;
    cpu_rd_c     = '0;
    mem_a_c      = bus.cpu_a;
    mem_sw_c     = 1'b0;
    mem_sh_c     = 1'b0;
    mem_sb_c     = 1'b0;
    if (rst) begin
      state_d      = S_IDLE;
      valid_d      = '0;
      hit_count_d  = '0;
      miss_count_d = '0;
    end else if (state_q == S_FILL) begin
      // cpu_a is held by the stalled pipeline, so idx/tag still name the missing line.
      stall_c     = 1'b1;
      mem_a_c     = {bus.cpu_a[ADDRESS_LENGTH-1:2], 2'b00};
      line_we     = 1'b1;
      tag_we      = 1'b1;
      line_wdata  = bus.mem_rd;
      valid_d[idx] = 1'b1;
      state_d     = S_IDLE;
    end else if (store) begin
      mem_sw_c = bus.cpu_sw;
      mem_sh_c = bus.cpu_sh;
      mem_sb_c = bus.cpu_sb;
      if (hit) begin
        if (contained) begin
          line_we = 1'b1;
        end else begin
          valid_d[idx] = 1'b0;
        end
      end
    end else if (bus.cpu_re) begin
      if (hit) begin
        cpu_rd_c    = line_cur >> {off, 3'b000};
        hit_count_d = (hit_count_q == 32'hFFFF_FFFF) ? hit_count_q : hit_count_q + 32'd1;
      end else begin
        stall_c      = 1'b1;
        miss_count_d = (miss_count_q == 32'hFFFF_FFFF) ? miss_count_q : miss_count_q + 32'd1;
        state_d      = S_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    valid_q      <= valid_d;
    hit_count_q  <= hit_count_d;
    miss_count_q <= miss_count_d;
  end

  // Tag and data arrays carry no reset; validity alone decides whether they are used.
  always_ff @(posedge clk) begin
    if (line_we) line_q[idx] <= line_wdata;
    if (tag_we)  tag_q[idx]  <= tag;
  end

  assign bus.cpu_rd     = cpu_rd_c;
  assign bus.stall      = stall_c;
  assign bus.mem_a      = mem_a_c;
  assign bus.mem_wd     = bus.cpu_wd;
  assign bus.mem_sw     = mem_sw_c;
  assign bus.mem_sh     = mem_sh_c;
  assign bus.mem_sb     = mem_sb_c;
  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
endmodule

// File: tb/tb_dcache_direct_wt.sv
// Bench for dcache_direct_wt: byte-array RAM, a line-level cache model checked every cycle,
// directed scenarios with literal expectations, then a randomized load/store phase.
module tb_dcache_direct_wt;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_direct_wt_if #(.ADDRESS_LENGTH(32)) bus ();
  dcache_direct_wt #(.ADDRESS_LENGTH(32), .SETS(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // RAM: 16 KiB window, byte addressed by a[13:0].
  logic [7:0] ram [0:16383];

  always_comb begin
    bus.mem_rd = {ram[14'(bus.mem_a + 32'd3)], ram[14'(bus.mem_a + 32'd2)],
                  ram[14'(bus.mem_a + 32'd1)], ram[14'(bus.mem_a)]};
  end

  always @(posedge clk) begin
    if (bus.mem_sb) begin
      ram[14'(bus.mem_a)] = bus.mem_wd[7:0];
    end else if (bus.mem_sh) begin
      ram[14'(bus.mem_a)]         = bus.mem_wd[7:0];
      ram[14'(bus.mem_a + 32'd1)] = bus.mem_wd[15:8];
    end else if (bus.mem_sw) begin
      for (int k = 0; k < 4; k++) ram[14'(bus.mem_a + 32'(k))] = bus.mem_wd[8*k +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: per index, whether it holds a word, which word address, and its bytes.
  bit          m_armed = 1'b0;
  bit          m_valid [64];
  logic [29:0] m_waddr [64];
  logic [7:0]  m_bytes [64][4];
  bit          m_fill;
  logic [31:0] m_hits, m_misses;

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[7:2]] && (m_waddr[a[7:2]] == a[31:2]);
  endfunction

  always @(posedge clk) begin
    int i, sz, o;
    i = int'(bus.cpu_a[7:2]);
    o = int'(bus.cpu_a[1:0]);
    if (rst) begin
      m_armed = 1'b1;
      for (int n = 0; n < 64; n++) m_valid[n] = 1'b0;
      m_fill = 1'b0;
      m_hits = 0;
      m_misses = 0;
    end else if (m_armed) begin
      if (m_fill) begin
        for (int k = 0; k < 4; k++) m_bytes[i][k] = ram[14'({bus.cpu_a[31:2], 2'b00} + 32'(k))];
        m_waddr[i] = bus.cpu_a[31:2];
        m_valid[i] = 1'b1;
        m_fill = 1'b0;
      end else if (bus.cpu_sb || bus.cpu_sh || bus.cpu_sw) begin
        sz = bus.cpu_sb ? 1 : (bus.cpu_sh ? 2 : 4);
        if (m_hit(bus.cpu_a)) begin
          if (o + sz <= 4) begin
            for (int k = 0; k < sz; k++) m_bytes[i][o + k] = bus.cpu_wd[8*k +: 8];
          end else begin
            m_valid[i] = 1'b0;
          end
        end
      end else if (bus.cpu_re) begin
        if (m_hit(bus.cpu_a)) begin
          if (m_hits != 32'hFFFF_FFFF) m_hits++;
        end else begin
          if (m_misses != 32'hFFFF_FFFF) m_misses++;
          m_fill = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [31:0] e_rd, e_ma, word;
    logic        e_stall;
    logic [2:0]  e_s;
    if (m_armed) begin
      e_rd = 0;
      e_stall = 1'b0;
      e_s = 3'b000;
      e_ma = bus.cpu_a;
      if (!rst) begin
        if (m_fill) begin
          e_stall = 1'b1;
          e_ma = {bus.cpu_a[31:2], 2'b00};
        end else if (bus.cpu_sb || bus.cpu_sh || bus.cpu_sw) begin
          e_s = {bus.cpu_sb, bus.cpu_sh, bus.cpu_sw};
        end else if (bus.cpu_re) begin
          if (m_hit(bus.cpu_a)) begin
            word = {m_bytes[bus.cpu_a[7:2]][3], m_bytes[bus.cpu_a[7:2]][2],
                    m_bytes[bus.cpu_a[7:2]][1], m_bytes[bus.cpu_a[7:2]][0]};
            e_rd = word >> (8 * int'(bus.cpu_a[1:0]));
          end else begin
            e_stall = 1'b1;
          end
        end
      end
      check("cyc_stall", 32'(bus.stall), 32'(e_stall));
      check("cyc_cpu_rd", bus.cpu_rd, e_rd);
      check("cyc_mem_a", bus.mem_a, e_ma);
      check("cyc_mem_strobes", 32'({bus.mem_sb, bus.mem_sh, bus.mem_sw}), 32'(e_s));
      if (!m_fill || rst) check("cyc_mem_wd", bus.mem_wd, bus.cpu_wd);
      check("cyc_hit_count", bus.hit_count, m_hits);
      check("cyc_miss_count", bus.miss_count, m_misses);
    end
  end

  task automatic set_in(input logic [31:0] a, input logic [31:0] wd,
                        input logic re, input logic sw, input logic sh, input logic sb);
    bus.cpu_a = a;
    bus.cpu_wd = wd;
    bus.cpu_re = re;
    bus.cpu_sw = sw;
    bus.cpu_sh = sh;
    bus.cpu_sb = sb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a load, hold it while stalled, return the data seen on the non-stalled cycle.
  task automatic do_load(input logic [31:0] a, output logic [31:0] data, output int stalls);
    stalls = 0;
    data = 0;
    set_in(a, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (!bus.stall) begin
        data = bus.cpu_rd;
        tick();
        set_in(a, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("load a=%h rd=%h stalls=%0d", a, data, stalls);
        return;
      end
      stalls++;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL load_timeout a=%h actual=stalled required=done", a);
    set_in(a, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] d, m0;
    int          s;
    bit          stalled;
    int          op;
    logic [31:0] a;

    for (int i = 0; i < 16384; i++) ram[i] = 8'($urandom);
    {ram[3], ram[2], ram[1], ram[0]} = 32'hDEAD_BEEF;
    {ram[16'h103], ram[16'h102], ram[16'h101], ram[16'h100]} = 32'h1234_5678;

    // Reset with a store on the inputs: nothing may reach the RAM.
    rst = 1'b1;
    set_in(32'h0001_0000, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_mem_sw", 32'(bus.mem_sw), 32'd0);
    check("rst_hit_count", bus.hit_count, 32'd0);
    check("rst_miss_count", bus.miss_count, 32'd0);
    tick();
    rst = 1'b0;
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    do_load(32'h0001_0000, d, s);
    check("cold_stalls", 32'(s), 32'd2);
    check("cold_rd", d, 32'hDEAD_BEEF);
    @(negedge clk);
    check("cold_miss_count", bus.miss_count, 32'd1);
    check("cold_hit_count", bus.hit_count, 32'd1);
    tick();

    do_load(32'h0001_0002, d, s);
    check("offset_stalls", 32'(s), 32'd0);
    check("offset_rd", d, 32'h0000_DEAD);

    set_in(32'h0001_0001, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("sb_mem_sb", 32'(bus.mem_sb), 32'd1);
    $display("store sb a=%h wd=%h", bus.cpu_a, bus.cpu_wd);
    tick();
    do_load(32'h0001_0000, d, s);
    check("sb_hit_stalls", 32'(s), 32'd0);
    check("sb_hit_rd", d, 32'hDEAD_55EF);

    m0 = bus.miss_count;
    do_load(32'h0001_0100, d, s);
    check("conflict1_stalls", 32'(s), 32'd2);
    check("conflict1_rd", d, 32'h1234_5678);
    do_load(32'h0001_0000, d, s);
    check("conflict2_stalls", 32'(s), 32'd2);
    check("conflict2_rd", d, 32'hDEAD_55EF);
    @(negedge clk);
    check("conflict_miss_delta", bus.miss_count - m0, 32'd2);
    tick();

    set_in(32'h0001_0001, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("store sw a=%h wd=%h", bus.cpu_a, bus.cpu_wd);
    tick();
    do_load(32'h0001_0000, d, s);
    check("cross_sw_stalls", 32'(s), 32'd2);
    check("cross_sw_rd", d, 32'hBBCC_DDEF);

    set_in(32'h0001_0200, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(32'h0001_0200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("fillrst_stall", 32'(bus.stall), 32'd0);
    check("fillrst_miss_count", bus.miss_count, 32'd0);
    tick();
    do_load(32'h0001_0200, d, s);
    check("fillrst_reload_stalls", 32'(s), 32'd2);

    // Randomized phase; inputs are held while the cache stalls, as a pipeline would.
    stalled = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!stalled) begin
        rst = ($urandom_range(0, 199) == 0);
        a = 32'h0001_0000 | (32'($urandom_range(0, 3)) << 8) |
            (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
        op = $urandom_range(0, 10);
        case (op)
          0, 1, 2, 3, 4: set_in(a, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
          5:  set_in(a, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
          6:  set_in(a, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
          7:  set_in(a, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
          8:  set_in(a, $urandom, 1'b1, 1'($urandom), 1'($urandom), 1'b1);
          9:  set_in(a, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
          default: set_in(a, $urandom, 1'b0, 1'b1, 1'b1, 1'($urandom));
        endcase
      end else begin
        rst = 1'b0;
      end
      @(negedge clk);
      stalled = bus.stall;
      $display("rand n=%0d rst=%0d a=%h re=%0d s=%0d%0d%0d stall=%0d rd=%h", n, rst, bus.cpu_a,
               bus.cpu_re, bus.cpu_sb, bus.cpu_sh, bus.cpu_sw, bus.stall, bus.cpu_rd);
      tick();
    end
    rst = 1'b0;
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Preload both counters one below saturation, then drive them past it.
    force dut.miss_count_d = 32'hFFFF_FFFE;
    force dut.hit_count_d  = 32'hFFFF_FFFE;
    tick();
    release dut.miss_count_d;
    release dut.hit_count_d;
    m_misses = 32'hFFFF_FFFE;
    m_hits   = 32'hFFFF_FFFE;
    do_load(32'h0001_3000, d, s);
    do_load(32'h0001_3400, d, s);
    @(negedge clk);
    check("sat_miss_count", bus.miss_count, 32'hFFFF_FFFF);
    check("sat_hit_count", bus.hit_count, 32'hFFFF_FFFF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
